// File: rtl/fu_alu.sv
// fu_alu: single-issue integer execute unit sitting between a reservation
// station and the reorder buffer. It holds one op at a time, walks it
// through IDLE -> EXEC -> HOLD and keeps the result steady until the ROB
// takes it.
//
// Ports
//   in_clk, in_rst                 clock, synchronous active-high reset
//   in_rs_alu_start                issue strobe from the reservation station
//   in_rs_alu_op                   operation (alu_op_t)
//   in_rs_alu_val_a/_val_b         operands
//   in_rs_alu_dst_rob_index        result tag
//   in_rs_alu_set_nzcv             op writes flags
//   in_rs_alu_nzcv                 incoming flags (CSEL condition / passthrough)
//   in_rs_instr_uses_nzcv          op reads flags (gates CSEL)
//   in_rob_accept                  ROB consumes the presented result
//   in_rob_is_mispred              flush the in-flight op
//   out_rs_alu_ready               unit can take an issue (registered)
//   out_rob_done                   result valid
//   out_rob_value                  result value
//   out_rob_dst_rob_index          result tag
//   out_rob_set_nzcv               result carries flags
//   out_rob_nzcv                   result flags

`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif

package fu_alu_pkg;
    typedef enum logic [3:0] {
        PLUS, MINUS, AND, ORR, EOR, ORN, LSL, LSR, ASR, MOV, MUL, CSEL
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;
endpackage

module fu_alu
    import fu_alu_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int ALU_CYCLES = 1
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    input  logic                     in_rs_alu_start,
    input  alu_op_t                  in_rs_alu_op,
    input  logic [`GPR_SIZE-1:0]     in_rs_alu_val_a,
    input  logic [`GPR_SIZE-1:0]     in_rs_alu_val_b,
    input  logic [`ROB_IDX_SIZE-1:0] in_rs_alu_dst_rob_index,
    input  logic                     in_rs_alu_set_nzcv,
    input  nzcv_t                    in_rs_alu_nzcv,
    input  logic                     in_rs_instr_uses_nzcv,
    input  logic                     in_rob_accept,
    input  logic                     in_rob_is_mispred,
    output logic                     out_rs_alu_ready,
    output logic                     out_rob_done,
    output logic [`GPR_SIZE-1:0]     out_rob_value,
    output logic [`ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
    output logic                     out_rob_set_nzcv,
    output nzcv_t                    out_rob_nzcv
);

    localparam int W     = `GPR_SIZE;
    localparam int RW    = `ROB_IDX_SIZE;
    // Multiplier bits of b consumed per EXEC cycle; MUL_CYCLES chunks cover all of b.
    localparam int CHUNK = (W + MUL_CYCLES - 1) / MUL_CYCLES;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

    // Control state
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, ready_d;

    // Output registers
    logic                done_q, done_d;
    logic [W-1:0]        value_q, value_d;
    logic [RW-1:0]       dsto_q, dsto_d;
    logic                seto_q, seto_d;
    nzcv_t               nzcvo_q, nzcvo_d;

    // Captured operands
    alu_op_t             op_q;
    logic [W-1:0]        a_q, b_q;
    logic [RW-1:0]       dst_q;
    logic                setf_q;
    nzcv_t               nzcv_in_q;
    logic                uses_q;

    // Iterative multiplier: accumulator plus shifting multiplicand/multiplier
    logic [W-1:0]        acc_q, mpa_q, mpb_q;
    logic [W-1:0]        acc_nxt;

    logic                issue_w;
    logic [W-1:0]        alu_res;
    nzcv_t               flags_res;

    // One partial-product step: a (W bits) times a CHUNK-wide slice of b.
    function automatic logic [W-1:0] mul_step(input logic [W-1:0] acc,
                                              input logic [W-1:0] a,
                                              input logic [CHUNK-1:0] bc);
        logic [W+CHUNK-1:0] p;
        p = {{CHUNK{1'b0}}, a} * {{W{1'b0}}, bc};
        return acc + p[W-1:0];
    endfunction

    function automatic logic [W-1:0] alu_eval(input alu_op_t op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic z_in,
                                              input logic uses,
                                              input logic [W-1:0] mul_res);
        logic [5:0] sh;
        logic [W-1:0] r;
        sh = b[5:0];
        r  = '0;
        case (op)
            PLUS:  r = a + b;
            MINUS: r = a - b;
            AND:   r = a & b;
            ORR:   r = a | b;
            EOR:   r = a ^ b;
            ORN:   r = a | ~b;
            LSL:   r = a << sh;
            LSR:   r = a >> sh;
            ASR:   r = $unsigned($signed(a) >>> sh);
            MOV:   r = b;
            MUL:   r = mul_res;
            // Without a flag dependency CSEL degenerates to selecting b.
            CSEL:  r = (uses && z_in) ? a : b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic nzcv_t alu_flags(input alu_op_t op,
                                        input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [W-1:0] r);
        logic [W:0] s;
        nzcv_t f;
        s   = '0;
        f.n = r[W-1];
        f.z = (r == '0);
        f.c = 1'b0;
        f.v = 1'b0;
        if (op == PLUS) begin
            s   = {1'b0, a} + {1'b0, b};
            f.c = s[W];
            f.v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end else if (op == MINUS) begin
            // a + ~b + 1: carry-out is the inverted borrow.
            s   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
            f.c = s[W];
            f.v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
        return f;
    endfunction

    // ready_q is high exactly in IDLE, so it alone qualifies the issue.
    assign issue_w = ready_q && in_rs_alu_start && !in_rob_is_mispred;

    always_comb begin
        acc_nxt   = mul_step(acc_q, mpa_q, mpb_q[CHUNK-1:0]);
        alu_res   = alu_eval(op_q, a_q, b_q, nzcv_in_q.z, uses_q, acc_nxt);
        flags_res = alu_flags(op_q, a_q, b_q, alu_res);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        value_d = value_q;
        dsto_d  = dsto_q;
        seto_d  = seto_q;
        nzcvo_d = nzcvo_q;

        if (in_rob_is_mispred) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_rs_alu_start) begin
                        state_d = S_EXEC;
                        cnt_d   = (in_rs_alu_op == MUL) ? CNT_W'(MUL_CYCLES - 1)
                                                        : CNT_W'(ALU_CYCLES - 1);
                    end
                end
                S_EXEC: begin
                    if (cnt_q == '0) begin
                        state_d = S_HOLD;
                        done_d  = 1'b1;
                        value_d = alu_res;
                        dsto_d  = dst_q;
                        seto_d  = setf_q;
                        nzcvo_d = setf_q ? flags_res : nzcv_in_q;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (in_rob_accept) begin
                        state_d = S_IDLE;
                        done_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            endcase
        end

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            value_q <= '0;
            dsto_q  <= '0;
            seto_q  <= 1'b0;
            nzcvo_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            value_q <= value_d;
            dsto_q  <= dsto_d;
            seto_q  <= seto_d;
            nzcvo_q <= nzcvo_d;
        end
    end

    // Operand capture at issue
    always_ff @(posedge in_clk) begin
        if (issue_w) begin
            op_q      <= in_rs_alu_op;
            a_q       <= in_rs_alu_val_a;
            b_q       <= in_rs_alu_val_b;
            dst_q     <= in_rs_alu_dst_rob_index;
            setf_q    <= in_rs_alu_set_nzcv;
            nzcv_in_q <= in_rs_alu_nzcv;
            uses_q    <= in_rs_instr_uses_nzcv;
        end
    end

    // Multiplier datapath: one CHUNK of b per EXEC cycle
    always_ff @(posedge in_clk) begin
        if (issue_w) begin
            acc_q <= '0;
            mpa_q <= in_rs_alu_val_a;
            mpb_q <= in_rs_alu_val_b;
        end else if (state_q == S_EXEC && op_q == MUL) begin
            acc_q <= acc_nxt;
            mpa_q <= mpa_q << CHUNK;
            mpb_q <= mpb_q >> CHUNK;
        end
    end

    assign out_rs_alu_ready      = ready_q;
    assign out_rob_done          = done_q;
    assign out_rob_value         = value_q;
    assign out_rob_dst_rob_index = dsto_q;
    assign out_rob_set_nzcv      = seto_q;
    assign out_rob_nzcv          = nzcvo_q;

endmodule

// File: tb/tb_fu_alu.sv
// Directed testbench for fu_alu: hand-computed vectors for every op,
// flag generation, latency, backpressure, flush and reset.

`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif

module tb_fu_alu;
    import fu_alu_pkg::*;

    localparam int MUL_CYC = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    alu_op_t                  rs_op;
    logic [`GPR_SIZE-1:0]     rs_a, rs_b;
    logic [`ROB_IDX_SIZE-1:0] rs_dst;
    logic                     rs_setf;
    nzcv_t                    rs_nzcv;
    logic                     rs_uses;
    logic                     accept;
    logic                     mispred;
    logic                     ready;
    logic                     done;
    logic [`GPR_SIZE-1:0]     value;
    logic [`ROB_IDX_SIZE-1:0] dst;
    logic                     seto;
    nzcv_t                    nzcvo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fu_alu #(.MUL_CYCLES(MUL_CYC), .ALU_CYCLES(1)) dut (
        .in_clk                  (clk),
        .in_rst                  (rst),
        .in_rs_alu_start         (start),
        .in_rs_alu_op            (rs_op),
        .in_rs_alu_val_a         (rs_a),
        .in_rs_alu_val_b         (rs_b),
        .in_rs_alu_dst_rob_index (rs_dst),
        .in_rs_alu_set_nzcv      (rs_setf),
        .in_rs_alu_nzcv          (rs_nzcv),
        .in_rs_instr_uses_nzcv   (rs_uses),
        .in_rob_accept           (accept),
        .in_rob_is_mispred       (mispred),
        .out_rs_alu_ready        (ready),
        .out_rob_done            (done),
        .out_rob_value           (value),
        .out_rob_dst_rob_index   (dst),
        .out_rob_set_nzcv        (seto),
        .out_rob_nzcv            (nzcvo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] d, input logic setf, input logic [3:0] nz,
                         input logic uses);
        rs_op   = op;
        rs_a    = a;
        rs_b    = b;
        rs_dst  = d;
        rs_setf = setf;
        rs_nzcv = nzcv_t'(nz);
        rs_uses = uses;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            step();
            n++;
        end
    endtask

    // Single-cycle op with accept held high: check latency, result, flags, release.
    task automatic run_op(input string tag, input alu_op_t op, input logic [63:0] a,
                          input logic [63:0] b, input logic setf, input logic [3:0] nz,
                          input logic uses, input logic [63:0] exp_v, input logic [3:0] exp_f);
        int n;
        accept = 1'b1;
        issue(op, a, b, 6'd33, setf, nz, uses);
        wait_done(10, n);
        chk({tag, "_lat"}, 64'(n), 64'd1);
        chk({tag, "_val"}, value, exp_v);
        chk({tag, "_nzcv"}, {60'b0, nzcvo}, {60'b0, exp_f});
        chk({tag, "_set"}, {63'b0, seto}, {63'b0, setf});
        chk({tag, "_dst"}, {58'b0, dst}, 64'd33);
        step();
        chk({tag, "_rel"}, {62'b0, done, ready}, 64'b01);
    endtask

    initial begin
        int n;
        int seen;
        logic [63:0] held_v;

        rst = 1'b1; start = 1'b0; rs_op = PLUS; rs_a = '0; rs_b = '0; rs_dst = '0;
        rs_setf = 1'b0; rs_nzcv = '0; rs_uses = 1'b0; accept = 1'b0; mispred = 1'b0;
        step();
        step();
        chk("rst_ready", {63'b0, ready}, 64'd1);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_value", value, 64'd0);
        chk("rst_dst", {58'b0, dst}, 64'd0);
        chk("rst_nzcv", {60'b0, nzcvo}, 64'd0);
        chk("rst_set", {63'b0, seto}, 64'd0);

        // First issue right after reset release, accept held high
        rst = 1'b0;
        accept = 1'b1;
        issue(PLUS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd5, 1'b1, 4'b0000, 1'b0);
        chk("plus_busy", {63'b0, ready}, 64'd0);
        wait_done(10, n);
        chk("plus_lat", 64'(n), 64'd1);
        chk("plus_val", value, 64'd0);
        chk("plus_nzcv", {60'b0, nzcvo}, 64'b0110);
        chk("plus_dst", {58'b0, dst}, 64'd5);
        chk("plus_set", {63'b0, seto}, 64'd1);
        step();
        chk("plus_rel", {62'b0, done, ready}, 64'b01);

        run_op("sub1", MINUS, 64'd3, 64'd5, 1'b1, 4'b0000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
        run_op("sub2", MINUS, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 4'b0000, 1'b0,
               64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
        run_op("addv", PLUS, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'b0000, 1'b0,
               64'h8000_0000_0000_0000, 4'b1001);
        run_op("and", AND, 64'hF0F0, 64'hFF00, 1'b0, 4'b1010, 1'b0, 64'hF000, 4'b1010);
        run_op("orr", ORR, 64'd1, 64'd2, 1'b0, 4'b0000, 1'b0, 64'd3, 4'b0000);
        run_op("eor", EOR, 64'hFF, 64'h0F, 1'b1, 4'b1111, 1'b0, 64'hF0, 4'b0000);
        run_op("orn", ORN, 64'd0, 64'hFFFF_FFFF_FFFF_FF00, 1'b1, 4'b0000, 1'b0, 64'hFF, 4'b0000);
        run_op("lsl", LSL, 64'd1, 64'h43, 1'b0, 4'b0000, 1'b0, 64'd8, 4'b0000);
        run_op("lsr", LSR, 64'h8000_0000_0000_0000, 64'd63, 1'b0, 4'b0000, 1'b0, 64'd1, 4'b0000);
        run_op("asr", ASR, 64'h8000_0000_0000_0000, 64'd4, 1'b1, 4'b0000, 1'b0,
               64'hF800_0000_0000_0000, 4'b1000);
        run_op("mov", MOV, 64'd5, 64'd9, 1'b1, 4'b0000, 1'b0, 64'd9, 4'b0000);
        run_op("csel_z", CSEL, 64'd11, 64'd22, 1'b0, 4'b0100, 1'b1, 64'd11, 4'b0100);
        run_op("csel_nz", CSEL, 64'd11, 64'd22, 1'b0, 4'b0000, 1'b1, 64'd22, 4'b0000);
        run_op("csel_nouse", CSEL, 64'd11, 64'd22, 1'b0, 4'b0100, 1'b0, 64'd22, 4'b0100);

        // MUL with a competing start during EXEC, then backpressure
        accept = 1'b0;
        issue(MUL, 64'd7, 64'h1_0000_0001, 6'd12, 1'b0, 4'b0000, 1'b0);
        issue(PLUS, 64'd1, 64'd1, 6'd9, 1'b0, 4'b0000, 1'b0);
        n = 1;
        while (!done && n < 20) begin
            chk("mul_busy", {63'b0, ready}, 64'd0);
            step();
            n++;
        end
        chk("mul_lat", 64'(n), 64'(MUL_CYC));
        chk("mul_val", value, 64'h7_0000_0007);
        chk("mul_dst", {58'b0, dst}, 64'd12);
        held_v = value;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("bp_done", {63'b0, done}, 64'd1);
            chk("bp_val", value, held_v);
            chk("bp_dst", {58'b0, dst}, 64'd12);
            chk("bp_ready", {63'b0, ready}, 64'd0);
        end
        accept = 1'b1;
        step();
        chk("bp_rel", {62'b0, done, ready}, 64'b01);

        // Flush a MUL two cycles after its start
        issue(MUL, 64'd3, 64'd4, 6'd20, 1'b0, 4'b0000, 1'b0);
        step();
        mispred = 1'b1;
        step();
        mispred = 1'b0;
        chk("flush_mul", {62'b0, done, ready}, 64'b01);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) seen++;
        end
        chk("flush_mul_nodone", 64'(seen), 64'd0);
        run_op("after_flush", PLUS, 64'd1, 64'd2, 1'b0, 4'b0000, 1'b0, 64'd3, 4'b0000);

        // Flush in the cycle the counter reaches zero
        issue(PLUS, 64'd1, 64'd1, 6'd7, 1'b0, 4'b0000, 1'b0);
        mispred = 1'b1;
        step();
        mispred = 1'b0;
        chk("flush_cnt0", {62'b0, done, ready}, 64'b01);
        step();
        chk("flush_cnt0_late", {63'b0, done}, 64'd0);

        // Start coincident with flush in IDLE is dropped
        rs_op = PLUS; rs_a = 64'd4; rs_b = 64'd4;
        start = 1'b1;
        mispred = 1'b1;
        step();
        start = 1'b0;
        mispred = 1'b0;
        chk("flush_start_ready", {63'b0, ready}, 64'd1);
        step();
        step();
        chk("flush_start_nodone", {63'b0, done}, 64'd0);

        // Reset while holding a result
        accept = 1'b0;
        issue(PLUS, 64'd10, 64'd20, 6'd9, 1'b1, 4'b0000, 1'b0);
        wait_done(10, n);
        chk("hold_val", value, 64'd30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("hrst_done", {63'b0, done}, 64'd0);
        chk("hrst_value", value, 64'd0);
        chk("hrst_dst", {58'b0, dst}, 64'd0);
        chk("hrst_nzcv", {60'b0, nzcvo}, 64'd0);
        chk("hrst_set", {63'b0, seto}, 64'd0);
        chk("hrst_ready", {63'b0, ready}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
